// File: rtl/mul_sequencer.sv
// mul_sequencer: latches multiply operands, strobes the shift-add multiplier,
// stalls the pipe while busy and returns the registered 2*WIDTH product.
// Ports: CLK, Reset (async, active-low), req, flush, op_a, op_b -> stall,
//   result, result_valid, err; multiplier side: mul_st, mul_a, mul_b,
//   mul_product, mul_done, mul_idle.
// Option: define MUL_SEQ_TIMEOUT_EN to bound BUSY by TIMEOUT cycles (ERR).
module mul_sequencer #(
  parameter int WIDTH     = 16,
  parameter int ST_CYCLES = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               req,
  input  logic               flush,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               stall,
  output logic [2*WIDTH-1:0] result,
  output logic               result_valid,
  output logic               err,
  output logic               mul_st,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_product,
  input  logic               mul_done,
  input  logic               mul_idle
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_DONE,
    S_DRAIN
`ifdef MUL_SEQ_TIMEOUT_EN
    ,
    S_ERR
`endif
  } state_t;

  localparam logic [3:0] ST_LOAD = 4'(ST_CYCLES - 1);

  state_t     state;
  logic [3:0] st_cnt;
  logic       rel;

`ifdef MUL_SEQ_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] to_cnt;
  assign rel = (state == S_DONE) | (state == S_ERR);
`else
  assign rel = (state == S_DONE);
  assign err = 1'b0;
`endif

  // Released in DONE/ERR so the instruction can retire.
  assign stall = req & ~flush & ~rel;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state        <= S_IDLE;
      st_cnt       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      mul_st       <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
`ifdef MUL_SEQ_TIMEOUT_EN
      to_cnt       <= '0;
      err          <= 1'b0;
`endif
    end else begin
      result_valid <= 1'b0;
`ifdef MUL_SEQ_TIMEOUT_EN
      err          <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (req && mul_idle && !flush) begin
            mul_a  <= op_a;
            mul_b  <= op_b;
            st_cnt <= ST_LOAD;
            mul_st <= 1'b1;
            state  <= S_START;
          end
        end
        S_START: begin
          if (flush) begin
            mul_st <= 1'b0;
            state  <= S_DRAIN;
          end else if (st_cnt == 4'd0) begin
            mul_st <= 1'b0;
            state  <= S_BUSY;
`ifdef MUL_SEQ_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end else begin
            st_cnt <= st_cnt - 4'd1;
          end
        end
        S_BUSY: begin
          // Flush outranks a coincident done.
          if (flush) begin
            state <= S_DRAIN;
          end else if (mul_done) begin
            result       <= mul_product;
            result_valid <= 1'b1;
            state        <= S_DONE;
`ifdef MUL_SEQ_TIMEOUT_EN
          end else if (to_cnt == TO_LAST) begin
            result       <= '0;
            result_valid <= 1'b1;
            err          <= 1'b1;
            state        <= S_ERR;
          end else begin
            to_cnt <= to_cnt + 8'd1;
`endif
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        S_DRAIN: begin
          if (mul_idle) state <= S_IDLE;
        end
`ifdef MUL_SEQ_TIMEOUT_EN
        S_ERR: begin
          state <= S_DRAIN;
        end
`endif
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed test of mul_sequencer against a small
// behavioural shift-add multiplier with programmable latency.
module tb_mul_sequencer;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        req = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        stall;
  logic [31:0] result;
  logic        result_valid;
  logic        err;
  logic        mul_st;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] mul_product;
  logic        mul_done;
  logic        mul_idle;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat = 4;
  int   m_cnt;
  logic [31:0] m_prod;
  logic hold = 1'b0;
  logic xdone = 1'b0;

  always #5 CLK = ~CLK;

  mul_sequencer #(.WIDTH(16), .ST_CYCLES(2), .TIMEOUT(8)) dut (
    .CLK(CLK),
    .Reset(Reset),
    .req(req),
    .flush(flush),
    .op_a(op_a),
    .op_b(op_b),
    .stall(stall),
    .result(result),
    .result_valid(result_valid),
    .err(err),
    .mul_st(mul_st),
    .mul_a(mul_a),
    .mul_b(mul_b),
    .mul_product(mul_product),
    .mul_done(mul_done),
    .mul_idle(mul_idle)
  );

  always @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      m_cnt  <= 0;
      m_prod <= '0;
    end else if (mul_st) begin
      m_cnt  <= lat;
      m_prod <= 32'(mul_a) * 32'(mul_b);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign mul_product = m_prod;
  assign mul_done    = (m_cnt == 1) | xdone;
  assign mul_idle    = (m_cnt == 0) & ~mul_st & ~hold;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input int l);
    op_a = a;
    op_b = b;
    lat  = l;
    req  = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] exp,
                            input int exp_cyc, input int cyc0,
                            input logic exp_err);
    int cyc;
    bit seen;
    cyc  = cyc0;
    seen = 1'b0;
    while (!seen && cyc < cyc0 + 300) begin
      @(negedge CLK);
      if (result_valid) begin
        seen = 1'b1;
        check({tag, "_cyc"}, 64'(cyc), 64'(exp_cyc));
        check({tag, "_res"}, 64'(result), 64'(exp));
        check({tag, "_stall"}, 64'(stall), 64'd0);
        check({tag, "_err"}, 64'(err), 64'(exp_err));
      end
      tick;
      cyc++;
    end
    if (!seen) check({tag, "_no_valid"}, 64'd0, 64'd1);
    req = 1'b0;
  endtask

  task automatic flush_run(input string tag, input logic [15:0] a,
                           input int l, input logic [31:0] prev);
    issue(a, a, l);
    repeat (5) tick;
    flush = 1'b1;
    @(negedge CLK);
    check({tag, "_fl_stall"}, 64'(stall), 64'd0);
    tick;
    flush = 1'b0;
    req   = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      check($sformatf("%s_v%0d", tag, k), 64'(result_valid), 64'd0);
      check($sformatf("%s_r%0d", tag, k), 64'(result), 64'(prev));
      check($sformatf("%s_s%0d", tag, k), 64'(mul_st), 64'd0);
      tick;
    end
  endtask

  initial begin
    repeat (3) tick;
    @(negedge CLK);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_st", 64'(mul_st), 64'd0);
    check("rst_a", 64'(mul_a), 64'd0);
    check("rst_b", 64'(mul_b), 64'd0);
    tick;
    Reset = 1'b1;
    tick;

    issue(16'h0003, 16'h0007, 4);
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      check($sformatf("t1_stall_c%0d", k), 64'(stall), 64'(k <= 7));
      check($sformatf("t1_st_c%0d", k), 64'(mul_st),
            64'(k == 2 || k == 3));
      check($sformatf("t1_valid_c%0d", k), 64'(result_valid),
            64'(k == 8));
      if (k == 8) check("t1_result", 64'(result), 64'h15);
      tick;
    end
    req = 1'b0;
    tick;

    issue(16'hFFFF, 16'hFFFF, 4);
    tick;
    op_a = '0;
    op_b = '0;
    @(negedge CLK);
    check("t2_mul_a", 64'(mul_a), 64'hFFFF);
    check("t2_mul_b", 64'(mul_b), 64'hFFFF);
    tick;
    wait_valid("t2", 32'hFFFE0001, 8, 3, 1'b0);
    tick;

    hold = 1'b1;
    issue(16'h1234, 16'h0010, 2);
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      check($sformatf("t3_stall_c%0d", k), 64'(stall), 64'd1);
      check($sformatf("t3_st_c%0d", k), 64'(mul_st), 64'd0);
      tick;
    end
    hold = 1'b0;
    wait_valid("t3", 32'h0001_2340, 11, 6, 1'b0);
    tick;

    issue(16'h00FF, 16'h0101, 3);
    tick;
    xdone = 1'b1;
    @(negedge CLK);
    check("t5_st_high", 64'(mul_st), 64'd1);
    check("t5_no_valid", 64'(result_valid), 64'd0);
    tick;
    xdone = 1'b0;
    wait_valid("t5", 32'h0000_FFFF, 7, 3, 1'b0);
    tick;

    flush_run("t4a", 16'h0100, 6, 32'h0000_FFFF);
    flush_run("t4b", 16'h0200, 3, 32'h0000_FFFF);

    issue(16'h0005, 16'h0009, 1);
    wait_valid("t6", 32'd45, 5, 1, 1'b0);
    tick;

`ifdef MUL_SEQ_TIMEOUT_EN
    issue(16'h0007, 16'h0007, 100);
    wait_valid("t7", 32'd0, 12, 1, 1'b1);
    repeat (110) tick;
    issue(16'h0002, 16'h0003, 1);
    wait_valid("t8", 32'd6, 5, 1, 1'b0);
    tick;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Sequences the shift-add multiplier unit for the execute stage. It latches the operands of a multiply instruction, drives the multiplier's start strobe, and waits for completion. While the multiplier is busy it stalls the pipeline, then hands the registered 32-bit product to the execute-stage result mux. It sits between the CTRL1/register-file outputs and the multiplier, replacing the direct start wiring.

## Interface
Parameters:
- `WIDTH`, 16: operand width; product width is 2*WIDTH.
- `ST_CYCLES`, 2: number of cycles `mul_st` is held high per start (range 1..15).
- `TIMEOUT`, 64: maximum cycles to wait in BUSY for `mul_done` (used only with the timeout feature).

Ports:
- `CLK`, in, 1: single system clock; all logic is rising-edge.
- `Reset`, in, 1: asynchronous, active-low reset.
- `req`, in, 1: multiply instruction present in execute (ctrl bit 5).
- `flush`, in, 1: pipeline flush; aborts the current request.
- `op_a`, in, WIDTH: multiplier operand (rs).
- `op_b`, in, WIDTH: multiplicand operand (rt).
- `stall`, out, 1: freezes PC/IF/CTRL1 while high.
- `result`, out, 2*WIDTH: registered product.
- `result_valid`, out, 1: one-cycle pulse; `result` is valid.
- `err`, out, 1: one-cycle timeout pulse (feature-dependent).
- `mul_st`, out, 1: start strobe to the multiplier.
- `mul_a`, out, WIDTH: latched operand A.
- `mul_b`, out, WIDTH: latched operand B.
- `mul_product`, in, 2*WIDTH: multiplier output.
- `mul_done`, in, 1: multiplier completion.
- `mul_idle`, in, 1: multiplier idle.

## Operation
- States: IDLE, START, BUSY, DONE, DRAIN (plus ERR with the timeout feature).
- IDLE:
  - If `req` & `mul_idle` & ~`flush`: latch `op_a`/`op_b` into `mul_a`/`mul_b`, go to START.
  - If `req` & ~`mul_idle`: stay in IDLE with stall high.
- START: `mul_st`=1 for exactly ST_CYCLES cycles (counted by a down-counter), then go to BUSY. `mul_done` is ignored in START.
- BUSY: on `mul_done`, capture `mul_product` into `result` and go to DONE.
- DONE: `result_valid`=1 and `stall`=0 for one cycle, then go to IDLE. If `req` is still high in the following IDLE cycle, it is a new instruction and a new operation starts.
- `stall` = `req` & (state != DONE) & ~`flush`.
- Flush:
  - In IDLE or DONE: go to IDLE.
  - In START or BUSY: drop `mul_st`, go to DRAIN, then leave DRAIN for IDLE on the first cycle `mul_idle`=1.
  - No `result_valid` is produced for a flushed operation.
- `result` holds its value until the next capture. `result` is never cleared except by reset or ERR.
- Width rule: product is unsigned WIDTH×WIDTH → 2*WIDTH with no truncation. `op_a`/`op_b` above WIDTH bits are the caller's responsibility.

## Timing
- Reset values: state=IDLE, `stall`=0, `result`=0, `result_valid`=0, `err`=0, `mul_st`=0, `mul_a`=0, `mul_b`=0, counters=0.
- Reset mid-operation returns to IDLE immediately. Because the multiplier may still be running, the first request after reset waits on `mul_idle`.
- Latency from request accepted to `result_valid` = 1 + ST_CYCLES + N + 1 cycles, where N = number of BUSY cycles until `mul_done`, N ≥ 1.
- `mul_st` asserts the cycle after acceptance and never overlaps `result_valid`.
- `mul_done` and `flush` in the same BUSY cycle: flush wins, go to DRAIN, no valid.
- `mul_done` held for multiple cycles: captured once only.

## Configuration
- `MUL_SEQ_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entering BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT without `mul_done`, go to ERR.
  - ERR: `result`=0, `err`=1 and `result_valid`=1 for one cycle, `stall`=0, then go to DRAIN.
- Not defined: BUSY waits indefinitely, `err` is tied to 0, no ERR state is synthesised.

## Test plan
- Reset low for 3 cycles → all outputs 0. `req`=1, `op_a`=16'h0003, `op_b`=16'h0007, model done after 4 BUSY cycles → `mul_st` high 2 cycles, `result`=32'h15 with `result_valid` pulse on cycle 8; `stall` high cycles 1–7.
- `op_a`=16'hFFFF, `op_b`=16'hFFFF → `result`=32'hFFFE0001.
- `req`=1 with `mul_idle`=0 for 5 cycles → stall high, `mul_st` low until `mul_idle` rises; then normal sequence.
- Flush during BUSY with the model still busy 3 more cycles → DRAIN for 3 cycles, no `result_valid`, `result` keeps its previous value.
- `mul_done` pulsed during START → ignored; only a done in BUSY captures.
- With `MUL_SEQ_TIMEOUT_EN`, TIMEOUT=8, done never asserted → `err`=1 and `result_valid`=1 with `result`=0 on BUSY cycle 8, stall released.
